// File: rtl/farm_queue_sensor.sv
// farm_queue_sensor
// -----------------
// Environment-side model of the farm-road vehicle queue that sits opposite
// the traffic light controller. It counts arriving cars and lets the head
// car cross after PASS_CYCLES consecutive green cycles. It also tracks how
// long the head car has been held, and raises sticky flags for starvation,
// dropped arrivals and illegal light codes. farm_light comes from a
// register in the controller, so closing the loop forms no combinational
// path.
//
// Ports:
//   clk           in  1            single clock
//   reset         in  1            synchronous, active-high; clears all state and flags
//   car_arrive    in  1            one car joins the queue per cycle it is high
//   farm_light    in  2            GREEN=0, YELLOW=1, RED=2, 3 is illegal (treated as RED)
//   car_present   out 1            queue_count != 0
//   queue_count   out QUEUE_WIDTH  cars queued, including the one crossing
//   car_depart    out 1            one-cycle pulse after each departure
//   wait_cycles   out WAIT_WIDTH   cycles the head car has spent blocked (saturating)
//   starve        out 1            sticky: wait_cycles reached MAX_WAIT
//   overflow      out 1            sticky: an arrival was dropped
//   illegal_light out 1            sticky: farm_light==3 was sampled

module farm_queue_sensor #(
    parameter int QUEUE_WIDTH = 4,
    parameter int PASS_CYCLES = 3,
    parameter int WAIT_WIDTH  = 6,
    parameter int MAX_WAIT    = 40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   car_arrive,
    input  logic [1:0]             farm_light,
    output logic                   car_present,
    output logic [QUEUE_WIDTH-1:0] queue_count,
    output logic                   car_depart,
    output logic [WAIT_WIDTH-1:0]  wait_cycles,
    output logic                   starve,
    output logic                   overflow,
    output logic                   illegal_light
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CROSS = 2'd2;

    localparam logic [1:0] LIGHT_GREEN   = 2'd0;
    localparam logic [1:0] LIGHT_ILLEGAL = 2'd3;

    localparam logic [QUEUE_WIDTH-1:0] QUEUE_FULL = {QUEUE_WIDTH{1'b1}};
    localparam logic [WAIT_WIDTH-1:0]  WAIT_SAT   = {WAIT_WIDTH{1'b1}};
    localparam logic [WAIT_WIDTH-1:0]  WAIT_LIMIT = WAIT_WIDTH'(MAX_WAIT);
    localparam logic [3:0]             PASS_LAST  = 4'(PASS_CYCLES - 1);

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [3:0]             pass_cnt;
    logic [3:0]             pass_next;
    logic [QUEUE_WIDTH-1:0] count_next;
    logic [WAIT_WIDTH-1:0]  wait_next;
    logic                   green;
    logic                   departure;
    logic                   accept;
    logic                   drop;

    // Queue bookkeeping: decide whether the head car leaves this cycle and
    // whether an arriving car fits. A departure in the same cycle frees a
    // slot, so a full queue still accepts an arrival when a car leaves.
    always_comb begin
        green      = (farm_light == LIGHT_GREEN);
        departure  = (state == ST_CROSS) && green && (pass_cnt == PASS_LAST);
        accept     = car_arrive && !((queue_count == QUEUE_FULL) && !departure);
        drop       = car_arrive && !accept;
        count_next = queue_count;
        if (accept && !departure) begin
            count_next = queue_count + 1'b1;
        end else if (!accept && departure) begin
            count_next = queue_count - 1'b1;
        end
    end

    // Head-car wait time: it restarts whenever a car leaves or the queue
    // drains, and only advances while the head car is blocked. It holds
    // during a crossing, so an interrupted crossing resumes counting from
    // the held value rather than from zero.
    always_comb begin
        wait_next = wait_cycles;
        if (departure || (count_next == '0)) begin
            wait_next = '0;
        end else if ((state == ST_WAIT) && (wait_cycles != WAIT_SAT)) begin
            wait_next = wait_cycles + 1'b1;
        end
    end

    // Crossing sequencer. Any non-green light (including the illegal code)
    // aborts a crossing and the head car starts over from zero. After a
    // departure the next car starts crossing immediately if the light is
    // still green, which gives one departure every PASS_CYCLES edges.
    always_comb begin
        state_next = state;
        pass_next  = pass_cnt;
        case (state)
            ST_IDLE: begin
                pass_next = '0;
                if (accept) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                pass_next = '0;
                if (green) begin
                    state_next = ST_CROSS;
                end
            end
            ST_CROSS: begin
                if (!green) begin
                    state_next = ST_WAIT;
                    pass_next  = '0;
                end else if (departure) begin
                    pass_next  = '0;
                    state_next = (count_next == '0) ? ST_IDLE : ST_CROSS;
                end else begin
                    pass_next = pass_cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pass_next  = '0;
            end
        endcase
    end

    // State and output registers. The sticky flags only ever set here;
    // reset is the single way to clear them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pass_cnt      <= '0;
            queue_count   <= '0;
            car_depart    <= 1'b0;
            wait_cycles   <= '0;
            starve        <= 1'b0;
            overflow      <= 1'b0;
            illegal_light <= 1'b0;
        end else begin
            state         <= state_next;
            pass_cnt      <= pass_next;
            queue_count   <= count_next;
            car_depart    <= departure;
            wait_cycles   <= wait_next;
            starve        <= starve | (wait_next >= WAIT_LIMIT);
            overflow      <= overflow | drop;
            illegal_light <= illegal_light | (farm_light == LIGHT_ILLEGAL);
        end
    end

    assign car_present = (queue_count != '0);

endmodule

// File: tb/tb_farm_queue_sensor.sv
// Testbench for farm_queue_sensor: directed scenarios plus randomized
// traffic, compared every cycle against a queue-level reference model.

module tb_farm_queue_sensor;

    localparam int QCAP   = 15;
    localparam int PASS   = 3;
    localparam int MAXW   = 40;
    localparam int WSAT   = 63;
    localparam logic [1:0] GREEN  = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] RED    = 2'd2;
    localparam logic [1:0] BAD    = 2'd3;

    logic       clk;
    logic       reset;
    logic       carArrive;
    logic [1:0] farmLight;
    logic       car_present;
    logic [3:0] queue_count;
    logic       car_depart;
    logic [5:0] wait_cycles;
    logic       starve;
    logic       overflow;
    logic       illegal_light;

    int errors = 0;
    int checks = 0;

    // Reference model state: cars queued, whether the head car is
    // crossing and how many green cycles it has accumulated, its wait.
    int mCount, mProgress, mWait;
    bit mCrossing, mDepart, mStarve, mOverflow, mIllegal;
    bit modelValid = 0;

    farm_queue_sensor #(
        .QUEUE_WIDTH(4), .PASS_CYCLES(PASS), .WAIT_WIDTH(6), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .car_arrive(carArrive),
        .farm_light(farmLight),
        .car_present(car_present),
        .queue_count(queue_count),
        .car_depart(car_depart),
        .wait_cycles(wait_cycles),
        .starve(starve),
        .overflow(overflow),
        .illegal_light(illegal_light)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs away from the clock edge, then return just
    // after the edge that sampled them.
    task automatic applyStimulus(input bit rst, input bit arr, input logic [1:0] light);
        @(negedge clk);
        reset     = rst;
        carArrive = arr;
        farmLight = light;
        @(posedge clk);
        #1;
    endtask

    // Reference model, expressed in terms of cars and green-cycle progress.
    always @(posedge clk) begin
        bit green, dep, acc, blocked;
        if (reset) begin
            mCount = 0; mProgress = 0; mWait = 0; mCrossing = 0;
            mDepart = 0; mStarve = 0; mOverflow = 0; mIllegal = 0;
        end else begin
            green   = (farmLight == GREEN);
            dep     = 0;
            blocked = (mCount > 0) && !mCrossing;
            if (mCount > 0) begin
                if (!mCrossing) begin
                    if (green) begin
                        mCrossing = 1;
                        mProgress = 0;
                    end
                end else if (!green) begin
                    mCrossing = 0;
                    mProgress = 0;
                end else if (mProgress == PASS - 1) begin
                    dep = 1;
                    mProgress = 0;
                end else begin
                    mProgress++;
                end
            end
            acc = carArrive && !(mCount == QCAP && !dep);
            if (carArrive && !acc) mOverflow = 1;
            mCount = mCount + int'(acc) - int'(dep);
            if (mCount == 0) mCrossing = 0;
            if (dep || mCount == 0) mWait = 0;
            else if (blocked && mWait < WSAT) mWait++;
            if (mWait >= MAXW) mStarve = 1;
            if (farmLight == BAD) mIllegal = 1;
            mDepart = dep;
        end
        modelValid = 1;
    end

    // Every cycle, all outputs must match the model.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("car_present",   int'(car_present),   int'(mCount != 0));
            checkOutput("queue_count",   int'(queue_count),   mCount);
            checkOutput("car_depart",    int'(car_depart),    int'(mDepart));
            checkOutput("wait_cycles",   int'(wait_cycles),   mWait);
            checkOutput("starve",        int'(starve),        int'(mStarve));
            checkOutput("overflow",      int'(overflow),      int'(mOverflow));
            checkOutput("illegal_light", int'(illegal_light), int'(mIllegal));
        end
    end

    initial begin
        reset = 1'b1; carArrive = 1'b0; farmLight = RED;
        applyStimulus(1, 0, RED);
        applyStimulus(1, 0, RED);
        checkOutput("reset_count", int'(queue_count), 0);
        checkOutput("reset_present", int'(car_present), 0);

        // Single car under continuous green: departs at e4.
        applyStimulus(0, 1, GREEN);
        checkOutput("single_present_e0", int'(car_present), 1);
        applyStimulus(0, 0, GREEN);
        applyStimulus(0, 0, GREEN);
        applyStimulus(0, 0, GREEN);
        checkOutput("single_no_depart_e3", int'(car_depart), 0);
        applyStimulus(0, 0, GREEN);
        checkOutput("single_depart_e4", int'(car_depart), 1);
        checkOutput("single_count_e4", int'(queue_count), 0);
        checkOutput("single_present_e4", int'(car_present), 0);
        applyStimulus(0, 0, GREEN);
        checkOutput("single_depart_pulse", int'(car_depart), 0);

        // Interrupted crossing.
        applyStimulus(0, 1, RED);
        applyStimulus(0, 0, RED);
        applyStimulus(0, 0, GREEN);
        checkOutput("intr_wait_e2", int'(wait_cycles), 2);
        applyStimulus(0, 0, GREEN);
        applyStimulus(0, 0, GREEN);
        applyStimulus(0, 0, YELLOW);
        checkOutput("intr_no_depart", int'(car_depart), 0);
        checkOutput("intr_count", int'(queue_count), 1);
        checkOutput("intr_wait_held", int'(wait_cycles), 2);
        applyStimulus(0, 0, RED);
        checkOutput("intr_wait_resume", int'(wait_cycles), 3);
        applyStimulus(0, 0, GREEN);
        applyStimulus(0, 0, GREEN);
        applyStimulus(0, 0, GREEN);
        checkOutput("intr_not_yet", int'(car_depart), 0);
        applyStimulus(0, 0, GREEN);
        checkOutput("intr_depart", int'(car_depart), 1);

        // Overflow: 16 arrivals on RED, then arrival coinciding with departure.
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, RED);
        checkOutput("ovf_count15", int'(queue_count), 15);
        checkOutput("ovf_not_yet", int'(overflow), 0);
        applyStimulus(0, 1, RED);
        checkOutput("ovf_count_hold", int'(queue_count), 15);
        checkOutput("ovf_flag", int'(overflow), 1);
        applyStimulus(0, 0, GREEN);
        applyStimulus(0, 0, GREEN);
        applyStimulus(0, 0, GREEN);
        applyStimulus(0, 1, GREEN);
        checkOutput("ovf_swap_depart", int'(car_depart), 1);
        checkOutput("ovf_swap_count", int'(queue_count), 15);

        // Starvation with RED held.
        applyStimulus(1, 0, RED);
        applyStimulus(0, 1, RED);
        for (int i = 1; i <= 39; i++) applyStimulus(0, 0, RED);
        checkOutput("starve_wait39", int'(wait_cycles), 39);
        checkOutput("starve_not_yet", int'(starve), 0);
        applyStimulus(0, 0, RED);
        checkOutput("starve_wait40", int'(wait_cycles), 40);
        checkOutput("starve_set", int'(starve), 1);
        for (int i = 0; i < 30; i++) applyStimulus(0, 0, RED);
        checkOutput("starve_saturate", int'(wait_cycles), 63);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, GREEN);
        checkOutput("starve_departed", int'(car_depart), 1);
        checkOutput("starve_sticky", int'(starve), 1);

        // Illegal light code with two cars queued, then a one-cycle reset.
        applyStimulus(1, 0, RED);
        applyStimulus(0, 1, BAD);
        applyStimulus(0, 1, BAD);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, BAD);
        checkOutput("illegal_flag", int'(illegal_light), 1);
        checkOutput("illegal_count", int'(queue_count), 2);
        checkOutput("illegal_wait", int'(wait_cycles), 4);
        applyStimulus(1, 0, GREEN);
        checkOutput("rst_count", int'(queue_count), 0);
        checkOutput("rst_present", int'(car_present), 0);
        checkOutput("rst_wait", int'(wait_cycles), 0);
        checkOutput("rst_flags", int'({starve, overflow, illegal_light, car_depart}), 0);

        // Closed-loop style light cycle (green 15, yellow 1, red 5) with
        // random arrivals: departures only under green, no starvation.
        applyStimulus(0, 0, RED);
        for (int c = 0; c < 400; c++) begin
            int ph;
            logic [1:0] l;
            ph = c % 21;
            l = (ph < 15) ? GREEN : (ph == 15) ? YELLOW : RED;
            applyStimulus(0, ($urandom_range(0, 99) < 30), l);
            if (car_depart) checkOutput("loop_depart_green", int'(farmLight), int'(GREEN));
        end
        checkOutput("loop_no_starve", int'(starve), 0);

        // Fully random lights, arrivals and occasional resets.
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 45),
                          2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
